// File: rtl/stream_in_port.sv
// stream_in_port: AXI4-Stream video receiver that frames pixels into a FIFO with line/frame alignment flags
module stream_in_port #(
   parameter int DSIZE = 24
) (
   input  logic             clock,
   input  logic             rst,
   input  logic [15:0]      vactive,
   input  logic [15:0]      hactive,
   input  logic [DSIZE-1:0] axi_tdata,
   input  logic             axi_tvalid,
   output logic             axi_tready,
   input  logic             axi_tuser,
   input  logic             axi_tlast,
   input  logic             fifo_full,
   output logic             wr_en,
   output logic [DSIZE-1:0] wr_data,
   output logic             falign,
   output logic             lalign,
   output logic             ealign,
   output logic             err_sof_early,
   output logic             err_eol_early,
   output logic             err_eol_late,
   output logic [15:0]      line_cnt,
   output logic [15:0]      pix_cnt
);
   typedef enum logic [1:0] {WAIT_SOF, ACTIVE, DROP} state_t;
   state_t state;
   logic en, acc, sof, dims_ok, wr, exp_eol, last_line;
   logic [15:0] hact_q, vact_q, hl, vl, p, l;
   // en holds ready low through reset and releases it one cycle later
   assign axi_tready = en & (state != ACTIVE | ~fifo_full);
   always_comb begin
      acc = axi_tvalid & axi_tready;
      sof = acc & axi_tuser;
      dims_ok = hactive != '0 && vactive != '0;
      hl = sof ? hactive : hact_q;
      vl = sof ? vactive : vact_q;
      p = sof ? '0 : pix_cnt;
      l = sof ? '0 : line_cnt;
      wr = sof ? dims_ok : acc & state == ACTIVE;
      exp_eol = p == hl - 16'd1;
      last_line = l == vl - 16'd1;
   end
   always_ff @(posedge clock) begin
      if (rst) begin
         state <= WAIT_SOF;
         en <= 1'b0;
         hact_q <= '0;
         vact_q <= '0;
         wr_en <= 1'b0;
         wr_data <= '0;
         falign <= 1'b0;
         lalign <= 1'b0;
         ealign <= 1'b0;
         err_sof_early <= 1'b0;
         err_eol_early <= 1'b0;
         err_eol_late <= 1'b0;
         line_cnt <= '0;
         pix_cnt <= '0;
      end else begin
         en <= 1'b1;
         wr_en <= wr;
         falign <= sof & dims_ok;
         lalign <= 1'b0;
         ealign <= 1'b0;
         err_sof_early <= sof & state != WAIT_SOF;
         err_eol_early <= 1'b0;
         err_eol_late <= 1'b0;
         if (sof) begin
            hact_q <= hactive;
            vact_q <= vactive;
         end
         if (wr) begin
            wr_data <= axi_tdata;
            if (axi_tlast | exp_eol) begin
               lalign <= 1'b1;
               err_eol_early <= ~exp_eol;
               err_eol_late <= ~axi_tlast;
               pix_cnt <= '0;
               if (!axi_tlast) begin
                  state <= DROP;
                  line_cnt <= l;
               end else begin
                  line_cnt <= l + 16'd1;
                  ealign <= last_line;
                  state <= last_line ? WAIT_SOF : ACTIVE;
               end
            end else begin
               pix_cnt <= p + 16'd1;
               line_cnt <= l;
               state <= ACTIVE;
            end
         end else if (sof) begin
            state <= WAIT_SOF;
         end else if (acc & state == DROP & axi_tlast) begin
            // overlong line finishes here; no write exists to carry ealign
            line_cnt <= line_cnt + 16'd1;
            pix_cnt <= '0;
            ealign <= last_line;
            state <= last_line ? WAIT_SOF : ACTIVE;
         end
      end
   end
endmodule
